fptd_iteration_ctrl: RTL and testbench
======================================

# fptd_iteration_ctrl

Iteration scheduler for the fully parallel turbo decoder array. Owns one frame decode at a time: accepts a start request, clears all section state, then alternates the odd-indexed and even-indexed section enables for a bounded number of iterations. Terminates early when the datapath reports stable hard decisions, then flushes the estimated-bit registers and signals completion. Sits between the frame-level host handshake and the `Enable`/`nClear` inputs of every decoder section.

## Interface
- `MAX_ITER`, default 8: maximum full iterations per frame (one odd step plus one even step); legal range 1..(2**ITER_W)-1.
- `MIN_ITER`, default 2: iterations completed before early termination may fire; 1..MAX_ITER.
- `ITER_W`, default 4: width of the iteration counter.
- `FLUSH_CYCLES`, default 2: idle cycles after the last even step, before `Done`; 1..15.
- `Clock`  in  1  single clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  frame start request; accepted only while `Ready`=1.
- `Abort`  in  1  cancels the frame in progress.
- `EarlyTermEn`  in  1  enables early termination.
- `HardStable`  in  1  datapath flag: no hard decision changed during the current iteration.
- `Ready`  out  1  idle; can accept `Start`.
- `Load`  out  1  one-cycle strobe; capture the channel LLR frame into the sections.
- `nClear`  out  1  active-low section clear, one cycle.
- `EnableOdd`  out  1  enable for odd-indexed sections.
- `EnableEven`  out  1  enable for even-indexed sections.
- `Busy`  out  1  frame in progress (not IDLE, not DONE).
- `Done`  out  1  one-cycle completion pulse.
- `EarlyTerm`  out  1  last frame ended by early termination; held until next `Load`.
- `IterCount`  out  ITER_W  iterations completed in the current or last frame.

## Operation
- Moore FSM. All outputs decode from registered state and counters only; there is no combinational input-to-output path.
- States: IDLE, LOAD, CLEAR, ODD, EVEN, FLUSH, DONE.
- IDLE: `Ready`=1. `Start`=1 with `Abort`=0 moves to LOAD.
- LOAD: `Load`=1. Clears `IterCount` and `EarlyTerm`. Moves to CLEAR.
- CLEAR: `nClear`=0. Moves to ODD.
- ODD: `EnableOdd`=1. Moves to EVEN.
- EVEN: `EnableEven`=1. `HardStable` is sampled in this cycle; `IterCount` increments on exit. Let n = `IterCount`+1.
  - If n == MAX_ITER, go to FLUSH.
  - Else if `EarlyTermEn` && `HardStable` && n >= MIN_ITER, go to FLUSH and set `EarlyTerm`=1.
  - Otherwise go to ODD.
- FLUSH: all enables are 0. A down-counter loads FLUSH_CYCLES-1 on entry and moves to DONE when it reaches 0.
- DONE: `Done`=1 for one cycle, then IDLE. `IterCount` and `EarlyTerm` hold until the next LOAD.
- `EnableOdd` and `EnableEven` are never high in the same cycle. Neither enable is high in LOAD or CLEAR.
- `Abort`:
  - In LOAD..FLUSH: go to IDLE next cycle, with no `Done`, all enables 0, and `IterCount` frozen.
  - In IDLE: `Abort` beats a simultaneous `Start`, so the request is dropped.
  - In DONE: ignored; the pulse completes.
- `Start` outside IDLE is ignored and not queued.
- Reset values: state IDLE, `Ready`=1, `nClear`=1, `Load`=0, `EnableOdd`=0, `EnableEven`=0, `Busy`=0, `Done`=0, `EarlyTerm`=0, `IterCount`=0. Reset mid-frame behaves like reset from any state.
- `IterCount` saturates at MAX_ITER and never wraps.

## Timing
- `Start` sampled at edge t:
  - `Load` is high in cycle t+1.
  - `nClear` is low in t+2.
  - The first `EnableOdd` is in t+3.
- For an exit after K iterations:
  - The last `EnableEven` is in t+2+2K.
  - FLUSH occupies t+3+2K .. t+2+2K+FLUSH_CYCLES.
  - `Done` is in t+3+2K+FLUSH_CYCLES.
  - `Ready` returns one cycle later.
- Frame latency with defaults and no early exit (K=8, FLUSH_CYCLES=2): `Done` 21 cycles after the `Start` edge.
- Back-to-back frames: the earliest next `Start` is accepted in the first IDLE cycle after DONE.

## Structure
- Package `fptd_ctrl_pkg` holds:
  - the state enum `fptd_ctrl_state_t`;
  - default constants `FPTD_MAX_ITER`, `FPTD_MIN_ITER`, `FPTD_FLUSH_CYCLES`;
  - an elaboration-time parameter legality check: MIN_ITER <= MAX_ITER, and MAX_ITER fits in ITER_W.
- Single module, no sub-modules. The FSM, iteration counter and flush counter fit in one block.

## Test plan
- Defaults, `EarlyTermEn`=0, `Start` at cycle 10:
  - `Load`@11, `nClear`=0@12, `EnableOdd` on 13,15,…,27, `EnableEven` on 14,…,28;
  - `Done`@31, `IterCount`=8, `EarlyTerm`=0.
- `EarlyTermEn`=1, `HardStable`=1 from the start:
  - exit after iteration 2 (MIN_ITER);
  - `Done` 9 cycles after the `Start` edge, `IterCount`=2, `EarlyTerm`=1.
- `HardStable` pulsed only during the 4th EVEN cycle with `EarlyTermEn`=1: `IterCount`=4, `EarlyTerm`=1.
- `Abort` during the 3rd ODD cycle:
  - IDLE next cycle, no `Done`, `IterCount`=2;
  - a new `Start` runs a full clean frame.
- `Start` and `Abort` together in IDLE: no `Load`. `Start` held during a frame: exactly one frame runs.
- `Reset` asserted mid-FLUSH: all outputs at reset values next cycle.
- Throughout all scenarios, assert `EnableOdd` && `EnableEven` never occurs.

Source files
------------

// File: rtl/fptd_ctrl_pkg.sv
// Shared state encoding, default parameters and parameter legality check
// for the fully parallel turbo decoder iteration scheduler.
package fptd_ctrl_pkg;

  localparam int unsigned FPTD_MAX_ITER     = 8;
  localparam int unsigned FPTD_MIN_ITER     = 2;
  localparam int unsigned FPTD_FLUSH_CYCLES = 2;
  localparam int unsigned FPTD_FLUSH_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_ODD   = 3'd3,
    ST_EVEN  = 3'd4,
    ST_FLUSH = 3'd5,
    ST_DONE  = 3'd6
  } fptd_ctrl_state_t;

  // True when the iteration bounds are consistent and MAX_ITER fits the counter.
  function automatic bit fptd_params_ok(input int unsigned max_iter,
                                        input int unsigned min_iter,
                                        input int unsigned iter_w,
                                        input int unsigned flush_cycles);
    bit ok;
    ok = (iter_w >= 1) && (iter_w <= 31);
    ok = ok && (max_iter >= 1) && ((max_iter >> iter_w) == 0);
    ok = ok && (min_iter >= 1) && (min_iter <= max_iter);
    ok = ok && (flush_cycles >= 1) && (flush_cycles <= 15);
    return ok;
  endfunction

endpackage

// File: rtl/fptd_iteration_ctrl.sv
// Frame-level iteration scheduler: load, clear, alternate odd/even section
// enables with bounded/early-terminated iterations, flush, then report done.
module fptd_iteration_ctrl
  import fptd_ctrl_pkg::*;
#(
  parameter int unsigned MAX_ITER     = FPTD_MAX_ITER,
  parameter int unsigned MIN_ITER     = FPTD_MIN_ITER,
  parameter int unsigned ITER_W       = 4,
  parameter int unsigned FLUSH_CYCLES = FPTD_FLUSH_CYCLES
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic              EarlyTermEn,
  input  logic              HardStable,
  output logic              Ready,
  output logic              Load,
  output logic              nClear,
  output logic              EnableOdd,
  output logic              EnableEven,
  output logic              Busy,
  output logic              Done,
  output logic              EarlyTerm,
  output logic [ITER_W-1:0] IterCount
);

  if (!fptd_params_ok(MAX_ITER, MIN_ITER, ITER_W, FLUSH_CYCLES)) begin : g_param_check
    $error("fptd_iteration_ctrl: illegal MAX_ITER/MIN_ITER/ITER_W/FLUSH_CYCLES");
  end

  localparam logic [ITER_W-1:0]       MAX_CNT    = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0]       MIN_CNT    = ITER_W'(MIN_ITER);
  localparam logic [FPTD_FLUSH_W-1:0] FLUSH_LOAD = FPTD_FLUSH_W'(FLUSH_CYCLES - 1);

  fptd_ctrl_state_t        state_q, state_d;
  logic [ITER_W-1:0]       iter_q, iter_d, iter_inc;
  logic [FPTD_FLUSH_W-1:0] flush_q, flush_d;
  logic                    early_q, early_d;

  logic ready_q, ready_d;
  logic load_q, load_d;
  logic nclear_q, nclear_d;
  logic odd_q, odd_d;
  logic even_q, even_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Next state and counters; abort in any busy state overrides everything.
  always_comb begin
    state_d  = state_q;
    iter_d   = iter_q;
    flush_d  = flush_q;
    early_d  = early_q;
    iter_inc = (iter_q >= MAX_CNT) ? iter_q : iter_q + ITER_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (Start && !Abort) begin
          state_d = ST_LOAD;
          iter_d  = '0;
          early_d = 1'b0;
        end
      end
      ST_LOAD:  state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_ODD;
      ST_ODD:   state_d = ST_EVEN;
      ST_EVEN: begin
        iter_d = iter_inc;
        if (iter_inc == MAX_CNT) begin
          state_d = ST_FLUSH;
          flush_d = FLUSH_LOAD;
        end else if (EarlyTermEn && HardStable && (iter_inc >= MIN_CNT)) begin
          state_d = ST_FLUSH;
          flush_d = FLUSH_LOAD;
          early_d = 1'b1;
        end else begin
          state_d = ST_ODD;
        end
      end
      ST_FLUSH: begin
        if (flush_q == '0) state_d = ST_DONE;
        else               flush_d = flush_q - FPTD_FLUSH_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (Abort && (state_q inside {ST_LOAD, ST_CLEAR, ST_ODD, ST_EVEN, ST_FLUSH})) begin
      state_d = ST_IDLE;
      iter_d  = iter_q;
      flush_d = flush_q;
      early_d = early_q;
    end

    ready_d  = (state_d == ST_IDLE);
    load_d   = (state_d == ST_LOAD);
    nclear_d = (state_d != ST_CLEAR);
    odd_d    = (state_d == ST_ODD);
    even_d   = (state_d == ST_EVEN);
    busy_d   = (state_d inside {ST_LOAD, ST_CLEAR, ST_ODD, ST_EVEN, ST_FLUSH});
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      iter_q   <= '0;
      flush_q  <= '0;
      early_q  <= 1'b0;
      ready_q  <= 1'b1;
      load_q   <= 1'b0;
      nclear_q <= 1'b1;
      odd_q    <= 1'b0;
      even_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      flush_q  <= flush_d;
      early_q  <= early_d;
      ready_q  <= ready_d;
      load_q   <= load_d;
      nclear_q <= nclear_d;
      odd_q    <= odd_d;
      even_q   <= even_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Ready      = ready_q;
  assign Load       = load_q;
  assign nClear     = nclear_q;
  assign EnableOdd  = odd_q;
  assign EnableEven = even_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign EarlyTerm  = early_q;
  assign IterCount  = iter_q;

endmodule

// File: tb/tb_fptd_iteration_ctrl.sv
// Directed self-checking bench for fptd_iteration_ctrl with default parameters.
module tb_fptd_iteration_ctrl;

  localparam int FC = 2;

  logic       Clock, Reset, Start, Abort, EarlyTermEn, HardStable;
  logic       Ready, Load, nClear, EnableOdd, EnableEven, Busy, Done, EarlyTerm;
  logic [3:0] IterCount;
  logic [6:0] obs;

  int compared   = 0;
  int mismatched = 0;

  fptd_iteration_ctrl dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort),
    .EarlyTermEn(EarlyTermEn), .HardStable(HardStable),
    .Ready(Ready), .Load(Load), .nClear(nClear),
    .EnableOdd(EnableOdd), .EnableEven(EnableEven), .Busy(Busy),
    .Done(Done), .EarlyTerm(EarlyTerm), .IterCount(IterCount)
  );

  assign obs = {Ready, Load, nClear, EnableOdd, EnableEven, Busy, Done};

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Enables must never overlap in any cycle.
  always @(negedge Clock) begin
    compared++;
    if (EnableOdd && EnableEven) begin
      mismatched++;
      $display("FAIL enable_overlap t=%0t odd=%b even=%b required=not both", $time, EnableOdd, EnableEven);
    end
  end

  // Expected {Ready,Load,nClear,Odd,Even,Busy,Done} in cycle k after the Start edge, kk iterations.
  function automatic logic [6:0] exp_vec(input int k, input int kk);
    int done_k;
    logic [6:0] v;
    done_k = 2 * kk + 3 + FC;
    v[6] = (k > done_k);
    v[5] = (k == 1);
    v[4] = (k != 2);
    v[3] = (k >= 3) && (k <= 2 * kk + 1) && (k % 2 == 1);
    v[2] = (k >= 4) && (k <= 2 * kk + 2) && (k % 2 == 0);
    v[1] = (k >= 1) && (k < done_k);
    v[0] = (k == done_k);
    return v;
  endfunction

  task automatic start_frame();
    @(negedge Clock);
    Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    compared++;
    if ({obs, EarlyTerm} !== 8'b1010_0000) begin
      mismatched++;
      $display("FAIL reset_outputs got=%b required=%b", {obs, EarlyTerm}, 8'b1010_0000);
    end
    compared++;
    if (IterCount !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_itercount got=%0d required=0", IterCount);
    end
    Reset = 1'b0;
  endtask

  task automatic test_full_frame();
    EarlyTermEn = 1'b0;
    HardStable  = 1'b0;
    start_frame();
    for (int k = 1; k <= 2 * 8 + 3 + FC + 2; k++) begin
      @(negedge Clock);
      compared++;
      if (obs !== exp_vec(k, 8)) begin
        mismatched++;
        $display("FAIL full_frame k=%0d got=%b required=%b", k, obs, exp_vec(k, 8));
      end
    end
    compared++;
    if ({EarlyTerm, IterCount} !== {1'b0, 4'd8}) begin
      mismatched++;
      $display("FAIL full_frame_result early=%b iter=%0d required early=0 iter=8", EarlyTerm, IterCount);
    end
  endtask

  task automatic test_early_term();
    EarlyTermEn = 1'b1;
    HardStable  = 1'b1;
    start_frame();
    for (int k = 1; k <= 2 * 2 + 3 + FC + 1; k++) begin
      @(negedge Clock);
      compared++;
      if (obs !== exp_vec(k, 2)) begin
        mismatched++;
        $display("FAIL early_term k=%0d got=%b required=%b", k, obs, exp_vec(k, 2));
      end
    end
    compared++;
    if ({EarlyTerm, IterCount} !== {1'b1, 4'd2}) begin
      mismatched++;
      $display("FAIL early_term_result early=%b iter=%0d required early=1 iter=2", EarlyTerm, IterCount);
    end
    HardStable = 1'b0;
  endtask

  task automatic test_stable_pulse();
    EarlyTermEn = 1'b1;
    HardStable  = 1'b0;
    start_frame();
    for (int k = 1; k <= 2 * 4 + 3 + FC + 1; k++) begin
      @(negedge Clock);
      compared++;
      if (obs !== exp_vec(k, 4)) begin
        mismatched++;
        $display("FAIL stable_pulse k=%0d got=%b required=%b", k, obs, exp_vec(k, 4));
      end
      if (k == 1) begin
        compared++;
        if ({EarlyTerm, IterCount} !== {1'b0, 4'd0}) begin
          mismatched++;
          $display("FAIL load_clears early=%b iter=%0d required early=0 iter=0", EarlyTerm, IterCount);
        end
      end
      HardStable = (k == 10);
    end
    compared++;
    if ({EarlyTerm, IterCount} !== {1'b1, 4'd4}) begin
      mismatched++;
      $display("FAIL stable_pulse_result early=%b iter=%0d required early=1 iter=4", EarlyTerm, IterCount);
    end
    EarlyTermEn = 1'b0;
  endtask

  task automatic test_abort();
    int dones;
    EarlyTermEn = 1'b0;
    start_frame();
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clock);
      compared++;
      if (obs !== exp_vec(k, 8)) begin
        mismatched++;
        $display("FAIL abort_prefix k=%0d got=%b required=%b", k, obs, exp_vec(k, 8));
      end
    end
    Abort = 1'b1;
    @(negedge Clock);
    Abort = 1'b0;
    compared++;
    if (obs !== 7'b1010000) begin
      mismatched++;
      $display("FAIL abort_idle got=%b required=%b", obs, 7'b1010000);
    end
    compared++;
    if (IterCount !== 4'd2) begin
      mismatched++;
      $display("FAIL abort_itercount got=%0d required=2", IterCount);
    end
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge Clock);
      if (Done) dones++;
    end
    compared++;
    if (dones != 0) begin
      mismatched++;
      $display("FAIL abort_no_done got=%0d required=0", dones);
    end
    start_frame();
    for (int k = 1; k <= 2 * 8 + 3 + FC + 1; k++) begin
      @(negedge Clock);
      compared++;
      if (obs !== exp_vec(k, 8)) begin
        mismatched++;
        $display("FAIL abort_restart k=%0d got=%b required=%b", k, obs, exp_vec(k, 8));
      end
    end
    compared++;
    if (IterCount !== 4'd8) begin
      mismatched++;
      $display("FAIL abort_restart_iter got=%0d required=8", IterCount);
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge Clock);
    Start = 1'b1;
    Abort = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    Abort = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clock);
      compared++;
      if ({Ready, Load, Busy} !== 3'b100) begin
        mismatched++;
        $display("FAIL start_abort_idle k=%0d got=%b required=100", k, {Ready, Load, Busy});
      end
    end
  endtask

  task automatic test_start_held();
    int loads;
    int dones;
    loads = 0;
    dones = 0;
    @(negedge Clock);
    Start = 1'b1;
    for (int k = 1; k <= 23; k++) begin
      @(negedge Clock);
      if (Load) loads++;
      if (Done) dones++;
      if (k == 21) Start = 1'b0;
    end
    compared++;
    if (loads != 1 || dones != 1) begin
      mismatched++;
      $display("FAIL start_held loads=%0d dones=%0d required 1 and 1", loads, dones);
    end
  endtask

  task automatic test_back_to_back();
    start_frame();
    for (int k = 1; k <= 2 * 8 + 3 + FC; k++) @(negedge Clock);
    compared++;
    if (Done !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_first_done got=%b required=1", Done);
    end
    @(negedge Clock);
    compared++;
    if (Ready !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_ready got=%b required=1", Ready);
    end
    Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
    for (int k = 1; k <= 2 * 8 + 3 + FC + 1; k++) begin
      @(negedge Clock);
      compared++;
      if (obs !== exp_vec(k, 8)) begin
        mismatched++;
        $display("FAIL b2b_second k=%0d got=%b required=%b", k, obs, exp_vec(k, 8));
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    start_frame();
    for (int k = 1; k <= 2 * 8 + 3; k++) @(negedge Clock);
    compared++;
    if ({Busy, EnableOdd, EnableEven, Done} !== 4'b1000) begin
      mismatched++;
      $display("FAIL flush_state got=%b required=1000", {Busy, EnableOdd, EnableEven, Done});
    end
    Reset = 1'b1;
    @(negedge Clock);
    compared++;
    if ({obs, EarlyTerm} !== 8'b1010_0000) begin
      mismatched++;
      $display("FAIL reset_mid_flush got=%b required=%b", {obs, EarlyTerm}, 8'b1010_0000);
    end
    compared++;
    if (IterCount !== 4'd0) begin
      mismatched++;
      $display("FAIL reset_mid_flush_iter got=%0d required=0", IterCount);
    end
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    compared++;
    if ({Ready, Done, Busy} !== 3'b100) begin
      mismatched++;
      $display("FAIL after_reset_idle got=%b required=100", {Ready, Done, Busy});
    end
  endtask

  initial begin
    Reset       = 1'b1;
    Start       = 1'b0;
    Abort       = 1'b0;
    EarlyTermEn = 1'b0;
    HardStable  = 1'b0;
    test_reset();
    repeat (3) @(negedge Clock);
    test_full_frame();
    test_early_term();
    test_stable_pulse();
    test_abort();
    test_start_abort_idle();
    test_start_held();
    test_back_to_back();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
